ddram_write_buffer: RTL

Write-side buffer between the screen-rotation framebuffer writer and the DDRAM controller port. It accepts single-cycle 64-bit write strobes, merges complementary half-word writes to the same DDRAM word, and queues the result in a FIFO. It drains the queue to DDRAM under the DDRAM_BUSY handshake, so pixel writes are no longer lost while the controller stalls.

---
 rtl/ddram_wr_pkg.sv | 30 +++
 rtl/ddram_write_buffer_fifo.sv | 56 +++++
 rtl/ddram_write_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ddram_wr_pkg.sv
// Shared widths and the request word carried from the framebuffer writer to the DDRAM port.
package ddram_wr_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [BE_W-1:0]   be;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // Bytes enabled in be come from new_d, all others keep old_d.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_d,
        input logic [DATA_W-1:0] new_d,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ddram_write_buffer_fifo.sv
// Synchronous show-ahead FIFO: dout_o is the head entry whenever empty_o is low.
module sc_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  wr_en;
    logic                  rd_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ddram_write_buffer.sv
// Write buffer in front of the DDRAM port: merges complementary partial writes to one word,
// queues them, and drains the queue under DDRAM_BUSY so no pixel write is lost on a stall.
module ddram_write_buffer
    import ddram_wr_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int MERGE      = 1,
    parameter int IDLE_FLUSH = 8
) (
    input  logic                  CLK_VIDEO,
    input  logic                  RESET,
    input  logic                  in_we,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_din,
    input  logic [BE_W-1:0]       in_be,
    input  logic                  DDRAM_BUSY,
    output logic [7:0]            DDRAM_BURSTCNT,
    output logic [ADDR_W-1:0]     DDRAM_ADDR,
    output logic [DATA_W-1:0]     DDRAM_DIN,
    output logic [BE_W-1:0]       DDRAM_BE,
    output logic                  DDRAM_WE,
    output logic                  DDRAM_RD,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int IDLE_W = $clog2(IDLE_FLUSH + 1) + 1;

    req_t              in_req;
    req_t              stg_q, stg_d;
    logic              stg_valid_q, stg_valid_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    req_t              slot_q;
    logic              slot_valid_q;
    logic              overflow_q;

    logic              idle_hit;
    logic              mergeable;
    logic              do_merge;
    logic              push_req;
    logic              drop;
    logic              slot_fire;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REQ_W-1:0]  fifo_dout;

    assign in_req = '{addr: in_addr, din: in_din, be: in_be};

    // The counter reaches IDLE_FLUSH on the edge that would follow an idle cycle here.
    assign idle_hit  = stg_valid_q && !in_we && ((int'(idle_q) + 1) >= IDLE_FLUSH);
    assign mergeable = (MERGE != 0) && stg_valid_q && (in_addr == stg_q.addr) &&
                       ((in_be & stg_q.be) == '0);
    assign do_merge  = in_we && mergeable;
    assign push_req  = stg_valid_q && !do_merge &&
                       (in_we || (stg_q.be == '1) || idle_hit || (MERGE == 0));

    // DDRAM handshake: the slot is valid (WE) until a rising edge sees BUSY low; the entry is
    // held unchanged while stalled, and a completing slot reloads from the FIFO in the same edge.
    assign slot_fire = slot_valid_q && !DDRAM_BUSY;
    assign fifo_pop  = (!slot_valid_q || slot_fire) && !fifo_empty;
    assign drop      = push_req && fifo_full && !fifo_pop;

    always_comb begin
        stg_d       = stg_q;
        stg_valid_d = stg_valid_q;
        idle_d      = idle_q;
        if (do_merge) begin
            stg_d.be  = stg_q.be | in_be;
            stg_d.din = merge_bytes(stg_q.din, in_din, in_be);
            idle_d    = '0;
        end else if (in_we) begin
            stg_d       = in_req;
            stg_valid_d = 1'b1;
            idle_d      = '0;
        end else if (push_req) begin
            stg_valid_d = 1'b0;
            idle_d      = '0;
        end else if (stg_valid_q && (int'(idle_q) < IDLE_FLUSH)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_VIDEO or posedge RESET) begin
        if (RESET) begin
            stg_q        <= '0;
            stg_valid_q  <= 1'b0;
            idle_q       <= '0;
            slot_q       <= '0;
            slot_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            stg_q       <= stg_d;
            stg_valid_q <= stg_valid_d;
            idle_q      <= idle_d;
            if (fifo_pop) begin
                slot_q       <= req_t'(fifo_dout);
                slot_valid_q <= 1'b1;
            end else if (slot_fire) begin
                slot_valid_q <= 1'b0;
            end
            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    sc_fifo #(
        .WIDTH      (REQ_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (CLK_VIDEO),
        .rst_i   (RESET),
        .push_i  (push_req),
        .din_i   (stg_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (level)
    );

    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = 1'b0;
    assign DDRAM_WE       = slot_valid_q;
    assign DDRAM_ADDR     = slot_q.addr;
    assign DDRAM_DIN      = slot_q.din;
    assign DDRAM_BE       = slot_q.be;
    assign overflow       = overflow_q;

endmodule
